cnn_layer_seq: RTL
==================

# cnn_layer_seq

Parametrised, clocked layer sequencer for the digit-recognition CNN accelerator. Software issues one `start`; the block steps through up to NUM_LAYERS configured layers in order, skipping masked-off layers. For each layer it releases that layer's memory-unit resets, drives the MAC/pooling mode lines, and collects sticky done flags. It reports progress, completion, timeout and abort status back to the register interface.

## Interface
- NUM_LAYERS, 6, number of layer slots (index 0 = image load … 5 = FC); 2..16
- NUM_UNITS, 12, number of memory read/write units with reset/done pairs
- TO_W, 20, width of the per-layer timeout counter
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low; all state returns to reset values immediately
- start  in  1  one-cycle pulse; begins a run from IDLE, DONE or ERR; ignored while busy
- abort  in  1  one-cycle pulse; returns to IDLE from any state; wins over start
- layer_en  in  NUM_LAYERS  per-layer enable, sampled on the start cycle
- cfg_kind  in  2*NUM_LAYERS  per-layer kind: 0 LOAD, 1 CONV, 2 POOL, 3 FC
- cfg_mac_sel  in  2*NUM_LAYERS  per-layer MAC weight-set select
- cfg_units  in  NUM_UNITS*NUM_LAYERS  per-layer mask of units the layer uses and waits on
- timeout_cycles  in  TO_W  RUN-cycle limit per layer; 0 disables the timeout
- unit_done  in  NUM_UNITS  level or pulse done flag from each memory unit
- unit_reset  out  NUM_UNITS  active-high reset to each memory unit
- mac_enable, rmac, pooling, img_load  out  1 each  datapath mode lines
- mac_layer  out  2  MAC weight-set select
- layer_onehot  out  NUM_LAYERS  layer currently in RUN
- busy, done, error  out  1 each  status flags
- status  out  8  count of layers completed in the current run; zero-extended

## Operation
- States: IDLE, ARM, RUN, DONE, ERR. Outputs are Moore-decoded from the registered state, cur_layer and the latched layer_en.
- Reset values: state IDLE; unit_reset all 1; rmac 1; mac_enable, pooling, img_load 0; mac_layer 0; layer_onehot 0; busy, done, error 0; status 0.
- IDLE, DONE or ERR, on start: latch layer_en, then find the lowest enabled layer.
  - If one is found: set cur_layer, go to ARM, clear status.
  - If none is enabled: go directly to DONE with status 0.
- ARM (one cycle): unit_reset all 1, rmac 1, mac_enable 0; clear done_seen and the timer; go to RUN.
- RUN, outputs:
  - unit_reset = ~cfg_units[cur_layer].
  - mac_enable = 1 when kind is CONV or FC; rmac = ~mac_enable.
  - pooling = 1 when kind is POOL; img_load = 1 when kind is LOAD.
  - mac_layer = cfg_mac_sel[cur_layer]; layer_onehot = 1<<cur_layer.
- RUN, done tracking: done_seen |= unit_done & mask each cycle. The layer completes when (done_seen | unit_done) covers the mask. An empty mask completes on the first RUN cycle.
- RUN, on completion:
  - status <= status+1.
  - Next higher enabled layer exists: update cur_layer and go to ARM.
  - Otherwise: go to DONE.
- RUN, timeout: when the timer reaches timeout_cycles (nonzero) without completion, go to ERR. Completion in the same cycle takes priority over timeout.
- DONE: done = 1 and status is held until the next start or abort.
- ERR: error = 1; layer_onehot keeps the failing layer; status is held; all unit_reset are 1.
- abort from any state: go to IDLE next edge, with reset-value outputs and status 0.
- cfg_* inputs must be stable while busy. unit_done is ignored outside RUN.

## Timing
- start sampled at edge 0 → ARM during cycle 1, RUN from cycle 2.
- Last required done seen in RUN cycle k → ARM in cycle k+1 and next layer's RUN in cycle k+2. Per-layer overhead is 1 cycle.
- status updates on the same edge that leaves RUN.
- busy = 1 in ARM and RUN only.
- Timer counts RUN cycles starting at 1; ERR is entered on the edge after the cycle where timer == timeout_cycles.
- Reset deassertion: first active edge in IDLE.

## Structure
- Package cnn_seq_pkg holds:
  - layer_kind_e (LOAD, CONV, POOL, FC) and seq_state_e.
  - Default parameter constants.
  - Helper localparam LW = $clog2(NUM_LAYERS).
- Sub-module cnn_next_layer: combinational priority finder. Given the enable vector and a start index, it returns the lowest enabled index ≥ start index plus a valid bit. It is used both at start and at each layer completion.

## Test plan
- Default run:
  - Setup: all 6 layers enabled; each unit asserts done 5 cycles after its reset releases.
  - Expected: 6 ARM/RUN pairs in order; status steps 1..6; done = 1; mac_enable high only in layers 1, 3, 5.
- Sparse mask:
  - Setup: layer_en = 6'b100101.
  - Expected: layer_onehot visits 0, 2, 5 only; final status 3.
  - Setup: layer_en = 0.
  - Expected: done the cycle after start, status 0.
- Pulsed dones:
  - Setup: layer 1's three units pulse done in cycles 3, 7 and 9 of RUN.
  - Expected: completion detected at cycle 9 via the sticky done_seen.
- Timeout:
  - Setup: timeout_cycles = 10; one unit never reports done.
  - Expected: ERR after 10 RUN cycles, error = 1, all unit_reset = 1, status = layers completed so far.
  - Follow-up: a new start re-runs from the lowest enabled layer.
- Abort and async reset:
  - abort together with start in IDLE → stays IDLE.
  - abort mid-RUN → IDLE next cycle with reset-value outputs.
  - reset asserted mid-RUN → outputs take reset values immediately, without a clock edge.

Source files
------------

// File: rtl/cnn_layer_seq_pkg.sv
// Shared types and default sizing for the CNN layer sequencer.
package cnn_seq_pkg;

   typedef enum logic [1:0] {
      K_LOAD = 2'd0,
      K_CONV = 2'd1,
      K_POOL = 2'd2,
      K_FC   = 2'd3
   } layer_kind_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE,
      S_ERR
   } seq_state_e;

   localparam int NUM_LAYERS_DEF = 6;
   localparam int NUM_UNITS_DEF  = 12;
   localparam int TO_W_DEF       = 20;
   localparam int LW             = $clog2(NUM_LAYERS_DEF);

endpackage

// File: rtl/cnn_layer_seq_if.sv
// Register-side and memory-unit-side signal bundle of the layer sequencer.
interface cnn_layer_seq_if
   import cnn_seq_pkg::*;
#(
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int NUM_UNITS  = NUM_UNITS_DEF,
   parameter int TO_W       = TO_W_DEF
);
   logic                            start;
   logic                            abort;
   logic [NUM_LAYERS-1:0]           layer_en;
   logic [2*NUM_LAYERS-1:0]         cfg_kind;
   logic [2*NUM_LAYERS-1:0]         cfg_mac_sel;
   logic [NUM_UNITS*NUM_LAYERS-1:0] cfg_units;
   logic [TO_W-1:0]                 timeout_cycles;
   logic [NUM_UNITS-1:0]            unit_done;
   logic [NUM_UNITS-1:0]            unit_reset;
   logic                            mac_enable;
   logic                            rmac;
   logic                            pooling;
   logic                            img_load;
   logic [1:0]                      mac_layer;
   logic [NUM_LAYERS-1:0]           layer_onehot;
   logic                            busy;
   logic                            done;
   logic                            error;
   logic [7:0]                      status;

   modport master (
      output start, abort, layer_en, cfg_kind, cfg_mac_sel, cfg_units,
             timeout_cycles, unit_done,
      input  unit_reset, mac_enable, rmac, pooling, img_load, mac_layer,
             layer_onehot, busy, done, error, status
   );

   modport slave (
      input  start, abort, layer_en, cfg_kind, cfg_mac_sel, cfg_units,
             timeout_cycles, unit_done,
      output unit_reset, mac_enable, rmac, pooling, img_load, mac_layer,
             layer_onehot, busy, done, error, status
   );
endinterface

// File: rtl/cnn_layer_seq_next_layer.sv
// Priority finder: lowest enabled layer index at or above from_i.
module cnn_next_layer #(
   parameter int NUM_LAYERS = 6,
   parameter int IW         = $clog2(NUM_LAYERS)
) (
   input  logic [NUM_LAYERS-1:0] en_i,
   input  logic [IW:0]           from_i,
   output logic [IW-1:0]         idx_o,
   output logic                  vld_o
);
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      // Scan downwards so the last hit left standing is the lowest index.
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (en_i[i] && (i >= int'(from_i))) begin
            idx_o = IW'(i);
            vld_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cnn_layer_seq.sv
// Layer sequencer for the digit-recognition CNN accelerator: walks the enabled
// layers in order, gating memory-unit resets and datapath mode lines per layer.
module cnn_layer_seq
   import cnn_seq_pkg::*;
#(
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int NUM_UNITS  = NUM_UNITS_DEF,
   parameter int TO_W       = TO_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   cnn_layer_seq_if.slave bus
);
   localparam int IW = $clog2(NUM_LAYERS);

   seq_state_e            state_q, state_d;
   logic [IW-1:0]         cur_q, cur_d;
   logic [NUM_LAYERS-1:0] en_q, en_d;
   logic [NUM_UNITS-1:0]  seen_q, seen_d;
   logic [TO_W-1:0]       timer_q, timer_d;
   logic [7:0]            status_q, status_d;

   logic                  idle_like;
   logic [NUM_LAYERS-1:0] find_en;
   logic [IW:0]           find_from;
   logic [IW-1:0]         find_idx;
   logic                  find_vld;
   logic [NUM_UNITS-1:0]  mask;
   layer_kind_e           kind;
   logic                  uses_mac;
   logic                  complete;
   logic                  timed_out;

   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
   // At start search the live enable vector from 0; otherwise search past the current layer.
   assign find_en   = idle_like ? bus.layer_en : en_q;
   assign find_from = idle_like ? '0 : ({1'b0, cur_q} + (IW+1)'(1));

   assign mask      = bus.cfg_units[cur_q*NUM_UNITS +: NUM_UNITS];
   assign kind      = layer_kind_e'(bus.cfg_kind[cur_q*2 +: 2]);
   assign uses_mac  = (kind == K_CONV) || (kind == K_FC);
   assign complete  = ((seen_q | bus.unit_done) & mask) == mask;
   assign timed_out = (bus.timeout_cycles != '0) && (timer_q == bus.timeout_cycles);

   cnn_next_layer #(.NUM_LAYERS(NUM_LAYERS), .IW(IW)) u_next (
      .en_i   (find_en),
      .from_i (find_from),
      .idx_o  (find_idx),
      .vld_o  (find_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cur_q    <= '0;
         en_q     <= '0;
         seen_q   <= '0;
         timer_q  <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         en_q     <= en_d;
         seen_q   <= seen_d;
         timer_q  <= timer_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      en_d     = en_q;
      seen_d   = seen_q;
      timer_d  = timer_q;
      status_d = status_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               en_d     = bus.layer_en;
               status_d = '0;
               if (find_vld) begin
                  cur_d   = find_idx;
                  state_d = S_ARM;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ARM: begin
            // Timer holds the 1-based index of the RUN cycle in progress.
            seen_d  = '0;
            timer_d = TO_W'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            seen_d  = seen_q | (bus.unit_done & mask);
            timer_d = timer_q + TO_W'(1);
            if (complete) begin
               status_d = status_q + 8'd1;
               if (find_vld) begin
                  cur_d   = find_idx;
                  state_d = S_ARM;
               end else begin
                  state_d = S_DONE;
               end
            end else if (timed_out) begin
               state_d = S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.abort) begin
         state_d  = S_IDLE;
         status_d = '0;
      end
   end

   always_comb begin
      bus.unit_reset   = '1;
      bus.mac_enable   = 1'b0;
      bus.rmac         = 1'b1;
      bus.pooling      = 1'b0;
      bus.img_load     = 1'b0;
      bus.mac_layer    = '0;
      bus.layer_onehot = '0;
      bus.busy         = 1'b0;
      bus.done         = 1'b0;
      bus.error        = 1'b0;
      case (state_q)
         S_ARM: bus.busy = 1'b1;
         S_RUN: begin
            bus.busy         = 1'b1;
            bus.unit_reset   = ~mask;
            bus.mac_enable   = uses_mac;
            bus.rmac         = ~uses_mac;
            bus.pooling      = (kind == K_POOL);
            bus.img_load     = (kind == K_LOAD);
            bus.mac_layer    = bus.cfg_mac_sel[cur_q*2 +: 2];
            bus.layer_onehot = NUM_LAYERS'(1) << cur_q;
         end
         S_DONE: bus.done = 1'b1;
         S_ERR: begin
            bus.error        = 1'b1;
            bus.layer_onehot = NUM_LAYERS'(1) << cur_q;
         end
         default: ;
      endcase
   end

   assign bus.status = status_q;

endmodule
